// File: rtl/scv_audio_out.sv
// scv_audio_out: APU PCM low-pass, 48 kHz decimation, DC blocker.
// Emits a signed 16-bit sample with a one-cycle valid strobe.
module scv_audio_out #(
  parameter int OUT_MUL  = 22,
  parameter int OUT_DIV  = 13125,
  parameter int LP_SHIFT = 4,
  parameter int DC_EN    = 1,
  parameter int DC_SHIFT = 10
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        AUD_CE,
  input  logic [8:0]  PCM_IN,
  input  logic        MUTE,
  output logic [15:0] SAMPLE,
  output logic        SAMPLE_VALID
);

  localparam logic [14:0] MUL = 15'(OUT_MUL);
  localparam logic [14:0] DIV = 15'(OUT_DIV);

  logic        [14:0] acc_q, acc_d, accn;
  logic               strobe;
  logic signed [17:0] lp_q, lp_d;
  logic signed [9:0]  x;
  logic signed [18:0] xs, lpe, diff, step;
  logic signed [15:0] s_reg_q, s_reg_d;
  logic signed [15:0] s_prev_q, s_prev_d;
  logic signed [15:0] hp_q, hp_d, hp_sh;
  logic signed [15:0] sample_q, sample_d;
  logic signed [15:0] dc_out, out_val;
  logic signed [17:0] h;
  logic               v1_q, v1_d;
  logic               valid_q, valid_d;

  function automatic logic signed [15:0] sat16(
    input logic signed [17:0] v
  );
    if (v > 18'sd32767)
      return 16'sh7fff;
    else if (v < -18'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  // Input low-pass and fractional output-rate accumulator.
  always_comb begin
    x      = $signed({1'b0, PCM_IN}) - 10'sd256;
    xs     = $signed({x[9], x, 8'h00});
    lpe    = $signed({lp_q[17], lp_q});
    diff   = xs - lpe;
    step   = diff >>> LP_SHIFT;
    lp_d   = AUD_CE ? lp_q + $signed(step[17:0]) : lp_q;
    accn   = acc_q + MUL;
    strobe = (accn >= DIV);
    acc_d  = strobe ? accn - DIV : accn;
  end

  // Capture and DC-block stages; lp is sampled before its own update.
  always_comb begin
    s_reg_d  = strobe ? lp_q[16:1] : s_reg_q;
    v1_d     = strobe;
    hp_sh    = hp_q >>> DC_SHIFT;
    h        = 18'(s_reg_q) - 18'(s_prev_q)
             + 18'(hp_q) - 18'(hp_sh);
    dc_out   = sat16(h);
    out_val  = (DC_EN != 0) ? dc_out : s_reg_q;
    hp_d     = hp_q;
    s_prev_d = s_prev_q;
    if (DC_EN != 0 && v1_q) begin
      hp_d     = dc_out;
      s_prev_d = s_reg_q;
    end
    sample_d = sample_q;
    if (v1_q)
      sample_d = MUTE ? 16'sd0 : out_val;
    valid_d  = v1_q;
  end

  // State registers.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      acc_q    <= '0;
      lp_q     <= '0;
      s_reg_q  <= '0;
      s_prev_q <= '0;
      hp_q     <= '0;
      v1_q     <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      lp_q     <= lp_d;
      s_reg_q  <= s_reg_d;
      s_prev_q <= s_prev_d;
      hp_q     <= hp_d;
      v1_q     <= v1_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign SAMPLE       = sample_q;
  assign SAMPLE_VALID = valid_q;

endmodule

// File: tb/tb_scv_audio_out.sv
// tb_scv_audio_out: scoreboard bench, DC off and DC on instances.
// Reference model is plain integer arithmetic on the signal path.
module tb_scv_audio_out;

  localparam int MUL = 22;
  localparam int DIV = 13125;
  localparam int LPS = 4;
  localparam int DCS = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ce = 1'b0;
  logic        mute = 1'b0;
  logic [8:0]  pcm = 9'd256;
  logic [15:0] s0, s1;
  logic        v0, v1;

  always #5 clk = ~clk;

  scv_audio_out #(
    .OUT_MUL(MUL), .OUT_DIV(DIV), .LP_SHIFT(LPS),
    .DC_EN(0), .DC_SHIFT(DCS)
  ) u_dc0 (
    .CLK(clk), .RESB(rst_n), .AUD_CE(ce),
    .PCM_IN(pcm), .MUTE(mute),
    .SAMPLE(s0), .SAMPLE_VALID(v0)
  );

  scv_audio_out #(
    .OUT_MUL(MUL), .OUT_DIV(DIV), .LP_SHIFT(LPS),
    .DC_EN(1), .DC_SHIFT(DCS)
  ) u_dc1 (
    .CLK(clk), .RESB(rst_n), .AUD_CE(ce),
    .PCM_IN(pcm), .MUTE(mute),
    .SAMPLE(s1), .SAMPLE_VALID(v1)
  );

  typedef struct {
    int     val;
    longint at_n;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     obs0[$];
  int     obs1[$];
  int     errors = 0;
  int     checks = 0;

  longint m_n = 0;
  int     m_lp = 0;
  int     m_hp = 0;
  int     m_sprev = 0;
  int     m_s = 0;
  int     m_h = 0;
  bit     m_pend = 0;

  longint first_at = -1;
  bit     win_on = 0;
  int     win_cnt = 0;
  int     ce_cnt = 1;
  int     ce_lo = 5;
  int     ce_hi = 6;

  function automatic int fdiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Output n-th edge carries a strobe when floor(n*MUL/DIV) steps.
  function automatic bit strobe_at(input longint n);
    return ((n * MUL) / DIV) != (((n - 1) * MUL) / DIV);
  endfunction

  task automatic check(input string name, input int act,
                       input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  task automatic check_true(input string name, input bit ok,
                            input int act);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d", name, act);
    end
  endtask

  // Reference model: expectations pushed at the edge the
  // output should appear on.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0;
      m_lp = 0;
      m_hp = 0;
      m_sprev = 0;
      m_s = 0;
      m_pend = 0;
      q0.delete();
      q1.delete();
    end else begin
      m_n++;
      if (m_pend) begin
        exp_t e;
        m_h = m_s - m_sprev + m_hp - fdiv(m_hp, 1 << DCS);
        m_hp = sat16(m_h);
        m_sprev = m_s;
        e.at_n = m_n;
        e.val = mute ? 0 : m_s;
        q0.push_back(e);
        e.val = mute ? 0 : m_hp;
        q1.push_back(e);
        m_pend = 0;
      end
      if (strobe_at(m_n)) begin
        m_s = fdiv(m_lp, 2);
        m_pend = 1;
      end
      if (ce)
        m_lp = m_lp
             + fdiv((int'(pcm) - 256) * 256 - m_lp, 1 << LPS);
    end
  end

  task automatic mon(input int id, input logic [15:0] s);
    exp_t e;
    int   a;
    a = int'($signed(s));
    if (id == 0) begin
      obs0.push_back(a);
      if (q0.size() == 0) begin
        check_true("dc0_unexpected_valid", 1'b0, a);
        return;
      end
      e = q0.pop_front();
    end else begin
      obs1.push_back(a);
      if (q1.size() == 0) begin
        check_true("dc1_unexpected_valid", 1'b0, a);
        return;
      end
      e = q1.pop_front();
    end
    check($sformatf("dc%0d_val", id), a, e.val);
    check($sformatf("dc%0d_at", id), int'(m_n), int'(e.at_n));
  endtask

  // Monitor: pops the scoreboard whenever a DUT strobes valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (v0) begin
        if (first_at < 0) first_at = m_n;
        if (win_on && m_n >= 2 && m_n <= 13126) win_cnt++;
        mon(0, s0);
      end
      if (v1) mon(1, s1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (ce_cnt <= 1) begin
      ce = 1'b1;
      ce_cnt = $urandom_range(ce_hi, ce_lo);
    end else begin
      ce = 1'b0;
      ce_cnt--;
    end
  endtask

  task automatic wait_samples(input int k);
    int tgt;
    int b;
    tgt = obs0.size() + k;
    b = 0;
    while (obs0.size() < tgt && b < k * 700 + 100) begin
      tick();
      b++;
    end
    check_true("sample_timeout", obs0.size() >= tgt, obs0.size());
  endtask

  task automatic reset_phase();
    rst_n = 1'b0;
    first_at = -1;
    repeat (10) begin
      tick();
      check("rst_s0", int'(s0), 0);
      check("rst_v0", int'(v0), 0);
      check("rst_s1", int'(s1), 0);
      check("rst_v1", int'(v1), 0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int b;
    int tgt;
    reset_phase();
    win_on = 1;

    b = 0;
    while (m_n < 13130 && b < 14000) begin
      tick();
      b++;
    end
    win_on = 0;
    // Valid is high in cycle 599, i.e. after the 598th edge.
    check("first_valid_edge", int'(first_at), 598);
    check("window_pulses", win_cnt, 22);
    foreach (obs0[i]) check("silence_dc0", obs0[i], 0);
    check("silence_dc1", obs1[obs1.size() - 1], 0);

    wait_samples(1);
    pcm = 9'd511;
    base = obs0.size();
    wait_samples(5);
    for (int i = 1; i < 5; i++)
      check_true("step_up_mono",
                 obs0[base + i] >= obs0[base + i - 1],
                 obs0[base + i]);
    check_true("step_up_level",
               obs0[base + 2] >= 32632 && obs0[base + 2] <= 32640,
               obs0[base + 2]);

    pcm = 9'd0;
    base = obs0.size();
    wait_samples(5);
    check("step_down_level", obs0[base + 4], -32768);

    wait_samples(1);
    b = 0;
    tick();
    while (!strobe_at(m_n + 1) && b < 700) begin
      tick();
      b++;
    end
    check_true("coincide_found", strobe_at(m_n + 1), b);
    pcm = 9'd511;
    ce = 1'b1;
    base = obs0.size();
    wait_samples(1);
    check("coincide_pre_lp", obs0[base], -32768);

    pcm = 9'd0;
    wait_samples(25);
    pcm = 9'd511;
    base = obs1.size();
    wait_samples(12);
    check("dc_step_sat", obs1[base], 32767);
    for (int i = 1; i < 12; i++)
      check_true("dc_decay_mono",
                 obs1[base + i] <= obs1[base + i - 1],
                 obs1[base + i]);
    check_true("dc_decay_falls",
               obs1[base + 11] < obs1[base + 3], obs1[base + 11]);
    check_true("dc_decay_pos", obs1[base + 11] > 0,
               obs1[base + 11]);

    mute = 1'b1;
    base = obs0.size();
    wait_samples(4);
    for (int i = 0; i < 4; i++) begin
      check("mute_dc0", obs0[base + i], 0);
      check("mute_dc1", obs1[base + i], 0);
    end
    mute = 1'b0;
    base = obs0.size();
    wait_samples(1);
    check_true("unmute_dc0",
               obs0[base] >= 32632 && obs0[base] <= 32640,
               obs0[base]);

    ce_lo = 1;
    ce_hi = 12;
    tgt = obs0.size() + 15;
    b = 0;
    while (obs0.size() < tgt && b < 15 * 700) begin
      base = obs0.size();
      tick();
      b++;
      if ($urandom_range(0, 3) == 0)
        pcm = 9'($urandom_range(0, 511));
      if (obs0.size() != base)
        mute = 1'($urandom_range(0, 1));
    end
    check_true("random_timeout", obs0.size() >= tgt, obs0.size());

    ce_lo = 5;
    ce_hi = 6;
    mute = 1'b0;
    reset_phase();
    wait_samples(1);
    check("reset_first_edge", int'(first_at), 598);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
